// File: rtl/freq_meas_pkg.sv
// -----------------------------------------------------------------------------
// freq_meas_pkg
//   Shared definitions for the frequency-measurement sequencer.
//   DUR_W   : width of a Divider high-phase duration
//   state_t : sequencer states
// -----------------------------------------------------------------------------
package freq_meas_pkg;

   localparam int unsigned DUR_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ARM,
      ST_WAIT,
      ST_ACCUM,
      ST_DONE
   } state_t;

endpackage

// File: rtl/freq_meas_ctrl_sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Two-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : asynchronous active-high reset, output resets to 0
//   d   : asynchronous input
//   q   : synchronized output (2 cycles of latency)
// -----------------------------------------------------------------------------
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= d;
         r_q    <= r_meta;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/freq_meas_ctrl.sv
// -----------------------------------------------------------------------------
// freq_meas_ctrl
//   Sequences the external high-phase counter (Divider): gates the synchronized
//   InFreq into it, clears it between samples, accumulates NUM_SAMPLES
//   durations and presents their average over a valid/ready handshake.
//   RefClk/rst            : clock, asynchronous active-high reset
//   start/continuous/abort: batch control
//   InFreq                : raw asynchronous signal under measurement
//   duration/complete     : Divider measurement result
//   gated_freq/div_clr    : Divider input and clear
//   result/result_valid/result_ready/timeout_err : averaged result handshake
//   busy                  : high whenever not idle
// -----------------------------------------------------------------------------
module freq_meas_ctrl
   import freq_meas_pkg::*;
#(
   parameter int unsigned LOG2_SAMPLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned TO_W           = 16
) (
   input  logic             RefClk,
   input  logic             rst,
   input  logic             start,
   input  logic             continuous,
   input  logic             abort,
   input  logic             InFreq,
   input  logic [DUR_W-1:0] duration,
   input  logic             complete,
   output logic             gated_freq,
   output logic             div_clr,
   output logic [DUR_W-1:0] result,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             timeout_err,
   output logic             busy
);

   localparam int unsigned NUM_SAMPLES = 1 << LOG2_SAMPLES;
   localparam int unsigned ACC_W       = DUR_W + LOG2_SAMPLES;
   localparam int unsigned CNT_W       = LOG2_SAMPLES + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   state_t             r_state, w_state_nxt;
   logic               r_meas_en, r_div_clr, r_valid, r_terr, r_busy;
   logic [DUR_W-1:0]   r_result, w_result_nxt;
   logic               w_valid_nxt, w_terr_nxt;
   logic [ACC_W-1:0]   r_acc, w_acc_nxt, w_acc_sum, w_avg;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [TO_W-1:0]    r_to_cnt, w_to_nxt;
   logic               w_sync;

   sync2 u_sync (
      .clk (RefClk),
      .rst (rst),
      .d   (InFreq),
      .q   (w_sync)
   );

   assign w_acc_sum = r_acc + ACC_W'(duration);
   assign w_avg     = w_acc_sum >> LOG2_SAMPLES;

   always_ff @(posedge RefClk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_meas_en <= 1'b0;
         r_div_clr <= 1'b1;
         r_busy    <= 1'b0;
         r_result  <= '0;
         r_valid   <= 1'b0;
         r_terr    <= 1'b0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_to_cnt  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         // Outputs are decoded from the next state so they line up with r_state
         r_meas_en <= (w_state_nxt == ST_WAIT);
         r_div_clr <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CLEAR);
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_result  <= w_result_nxt;
         r_valid   <= w_valid_nxt;
         r_terr    <= w_terr_nxt;
         r_acc     <= w_acc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_to_cnt  <= w_to_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_result_nxt = r_result;
      w_valid_nxt  = r_valid;
      w_terr_nxt   = r_terr;
      w_acc_nxt    = r_acc;
      w_cnt_nxt    = r_cnt;
      // Held at zero outside WAIT, so every WAIT entry starts a fresh timeout
      w_to_nxt     = '0;

      if (abort) begin
         w_state_nxt = ST_IDLE;
         w_valid_nxt = 1'b0;
         w_acc_nxt   = '0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_nxt = ST_CLEAR;
                  w_acc_nxt   = '0;
                  w_cnt_nxt   = '0;
               end
            end
            ST_CLEAR: w_state_nxt = ST_ARM;
            ST_ARM: begin
               // Only open the gate while low so Divider never sees a truncated high phase
               if (!w_sync) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
               w_to_nxt = r_to_cnt + TO_W'(1);
               if (complete) begin
                  w_state_nxt = ST_ACCUM;
               end else if (r_to_cnt == TO_LAST) begin
                  w_state_nxt  = ST_DONE;
                  w_valid_nxt  = 1'b1;
                  w_terr_nxt   = 1'b1;
                  w_result_nxt = '0;
               end
            end
            ST_ACCUM: begin
               w_acc_nxt = w_acc_sum;
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt  = ST_DONE;
                  w_valid_nxt  = 1'b1;
                  w_terr_nxt   = 1'b0;
                  w_result_nxt = DUR_W'(w_avg);
               end else begin
                  w_state_nxt = ST_CLEAR;
               end
            end
            ST_DONE: begin
               if (result_ready) begin
                  w_valid_nxt = 1'b0;
                  if (continuous) begin
                     w_state_nxt = ST_CLEAR;
                     w_acc_nxt   = '0;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign gated_freq   = w_sync & r_meas_en;
   assign div_clr      = r_div_clr;
   assign result       = r_result;
   assign result_valid = r_valid;
   assign timeout_err  = r_terr;
   assign busy         = r_busy;

endmodule
